// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_ctrl_pkg
//  Description : Shared definitions for the register-file instruction
//                sequencer: opcode values, instruction field positions,
//                sequencer state encoding and the write-op classifier.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

    // Opcode values, instruction bits [15:12]
    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_AND  = 4'h2;
    localparam logic [3:0] c_OP_OR   = 4'h3;
    localparam logic [3:0] c_OP_XOR  = 4'h4;
    localparam logic [3:0] c_OP_MOV  = 4'h5;
    localparam logic [3:0] c_OP_CMP  = 4'h6;
    localparam logic [3:0] c_OP_ADDI = 4'h8;
    localparam logic [3:0] c_OP_MOVI = 4'h9;
    localparam logic [3:0] c_OP_MUL  = 4'hA;
    localparam logic [3:0] c_OP_NOP  = 4'hF;

    // Instruction field bit positions
    localparam int c_OPC_MSB = 15;
    localparam int c_OPC_LSB = 12;
    localparam int c_RD_MSB  = 11;
    localparam int c_RD_LSB  = 8;
    localparam int c_RS_MSB  = 3;
    localparam int c_RS_LSB  = 0;
    localparam int c_IMM_MSB = 7;
    localparam int c_IMM_LSB = 0;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // True for every opcode that writes its rdest register at writeback.
    function automatic logic is_write_op(input logic [3:0] opcode);
        logic w_wr;
        case (opcode)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_MOV,
            c_OP_ADDI, c_OP_MOVI, c_OP_MUL: w_wr = 1'b1;
            default:                         w_wr = 1'b0;
        endcase
        return w_wr;
    endfunction

endpackage : regfile_ctrl_pkg
`default_nettype wire

// File: rtl/regfile_seq_decode.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_seq_decode
//  Description : Combinational decoder for the latched instruction word.
//                Produces ALU controls and the classification flags the
//                sequencer needs (write target, multi-cycle, illegal).
//  Ports       : instr_q     [15:0]   latched instruction word
//                alu_op      [3:0]    opcode passed to the ALU
//                b_sel_imm            ALU B operand comes from imm_out
//                imm_out     [DATA_W] sign-extended imm8
//                writes_reg           op writes rdest at writeback
//                writes_flag          op writes the flag register
//                is_mul               op needs the multi-cycle EXEC
//                illegal_op           opcode is undefined
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_seq_decode
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [15:0]       instr_q,
    output logic [3:0]        alu_op,
    output logic              b_sel_imm,
    output logic [DATA_W-1:0] imm_out,
    output logic              writes_reg,
    output logic              writes_flag,
    output logic              is_mul,
    output logic              illegal_op
);

    logic [3:0] w_opcode;
    logic [7:0] w_imm8;
    logic       w_unused_rdest;

    assign w_opcode = instr_q[c_OPC_MSB:c_OPC_LSB];
    assign w_imm8   = instr_q[c_IMM_MSB:c_IMM_LSB];

    // The register selects are routed by the sequencer, not decoded here.
    assign w_unused_rdest = ^instr_q[c_RD_MSB:c_RD_LSB];

    always_comb begin
        alu_op      = w_opcode;
        imm_out     = {{(DATA_W-8){w_imm8[7]}}, w_imm8};
        b_sel_imm   = (w_opcode == c_OP_ADDI) || (w_opcode == c_OP_MOVI);
        writes_reg  = is_write_op(w_opcode);
        writes_flag = (w_opcode == c_OP_CMP);
        is_mul      = (w_opcode == c_OP_MUL);
        case (w_opcode)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_MOV,
            c_OP_CMP, c_OP_ADDI, c_OP_MOVI, c_OP_MUL, c_OP_NOP:
                     illegal_op = 1'b0;
            default: illegal_op = 1'b1;
        endcase
    end

endmodule : regfile_seq_decode
`default_nettype wire

// File: rtl/regfile_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_seq_ctrl
//  Description : Instruction sequencer for the register file / ALU pair.
//                Accepts one instruction over valid/ready, walks it through
//                DECODE, EXEC (MUL_CYCLES cycles for MUL) and WB, and issues
//                a one-cycle one-hot register write or flag write at WB.
//  Ports       : clk                   clock, rising edge
//                reset                 synchronous active-high reset
//                instr       [15:0]    instruction word
//                instr_valid           source offers a word
//                instr_ready           sequencer idle and accepting
//                alu_op      [3:0]     ALU opcode
//                rd_a_sel    [3:0]     read port A select (rdest)
//                rd_b_sel    [3:0]     read port B select (rsrc)
//                b_sel_imm             ALU B operand is imm_out
//                imm_out     [DATA_W]  sign-extended imm8
//                reg_en      [NUM_REGS] one-hot register write enable
//                flag_en               flag register write enable
//                done                  instruction retired (pulse)
//                illegal               undefined opcode dropped (pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_seq_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int DATA_W     = 16,
    parameter int MUL_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [3:0]          alu_op,
    output logic [3:0]          rd_a_sel,
    output logic [3:0]          rd_b_sel,
    output logic                b_sel_imm,
    output logic [DATA_W-1:0]   imm_out,
    output logic [NUM_REGS-1:0] reg_en,
    output logic                flag_en,
    output logic                done,
    output logic                illegal
);

    // Counter must hold MUL_CYCLES-1; keep at least one bit when MUL_CYCLES=1.
    localparam int c_CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_instr_q;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_accept;

    logic [3:0]           w_alu_op;
    logic                 w_b_sel_imm;
    logic [DATA_W-1:0]    w_imm_out;
    logic                 w_writes_reg;
    logic                 w_writes_flag;
    logic                 w_is_mul;
    logic                 w_illegal_op;
    logic [NUM_REGS-1:0]  w_rd_onehot;

    regfile_seq_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .instr_q     (r_instr_q),
        .alu_op      (w_alu_op),
        .b_sel_imm   (w_b_sel_imm),
        .imm_out     (w_imm_out),
        .writes_reg  (w_writes_reg),
        .writes_flag (w_writes_flag),
        .is_mul      (w_is_mul),
        .illegal_op  (w_illegal_op)
    );

    assign w_accept    = (r_state == ST_IDLE) && instr_valid;
    assign w_rd_onehot = NUM_REGS'(1) << r_instr_q[c_RD_MSB:c_RD_LSB];

    // ------------------------------------------------------------------
    // State, instruction latch and EXEC counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_instr_q <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_instr_q <= instr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        instr_ready = 1'b0;
        reg_en      = '0;
        flag_en     = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;

        // Datapath controls follow the latched word in every state, so they
        // are stable from DECODE through the WB capture edge and simply hold
        // the previous instruction while idle.
        alu_op    = w_alu_op;
        rd_a_sel  = r_instr_q[c_RD_MSB:c_RD_LSB];
        rd_b_sel  = r_instr_q[c_RS_MSB:c_RS_LSB];
        b_sel_imm = w_b_sel_imm;
        imm_out   = w_imm_out;

        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_illegal_op) begin
                    illegal     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_EXEC;
                    w_cnt_nxt   = w_is_mul ? c_MUL_LOAD : '0;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WB;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            ST_WB: begin
                done        = 1'b1;
                flag_en     = w_writes_flag;
                reg_en      = w_writes_reg ? w_rd_onehot : '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // While reset is high every output is quiet, which also drops a
        // writeback that happens to coincide with reset.
        if (reset) begin
            instr_ready = 1'b0;
            reg_en      = '0;
            flag_en     = 1'b0;
            done        = 1'b0;
            illegal     = 1'b0;
            alu_op      = '0;
            rd_a_sel    = '0;
            rd_b_sel    = '0;
            b_sel_imm   = 1'b0;
            imm_out     = '0;
        end
    end

endmodule : regfile_seq_ctrl
`default_nettype wire

// File: tb/tb_regfile_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_seq_ctrl
//  Description : Self-checking bench for regfile_seq_ctrl. A transaction
//                level model predicts every output on every cycle from the
//                instruction timeline; directed sequences pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_seq_ctrl;

    localparam int NUM_REGS   = 16;
    localparam int DATA_W     = 16;
    localparam int MUL_CYCLES = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [15:0]         instr;
    logic                instr_valid;
    logic                instr_ready;
    logic [3:0]          alu_op;
    logic [3:0]          rd_a_sel;
    logic [3:0]          rd_b_sel;
    logic                b_sel_imm;
    logic [DATA_W-1:0]   imm_out;
    logic [NUM_REGS-1:0] reg_en;
    logic                flag_en;
    logic                done;
    logic                illegal;

    regfile_seq_ctrl #(
        .NUM_REGS   (NUM_REGS),
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_op      (alu_op),
        .rd_a_sel    (rd_a_sel),
        .rd_b_sel    (rd_b_sel),
        .b_sel_imm   (b_sel_imm),
        .imm_out     (imm_out),
        .reg_en      (reg_en),
        .flag_en     (flag_en),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int done_seen  = 0;

    // ------------------------------------------------------------------
    // Reference model: one instruction in flight, timed by cycles since
    // acceptance (1 = decode, last = writeback at exec_len+2).
    // ------------------------------------------------------------------
    bit          m_act  = 1'b0;
    bit          m_acc  = 1'b0;
    int          m_t    = 0;
    logic [15:0] m_last = 16'h0000;

    function automatic int exec_len(input logic [3:0] op);
        return (op == 4'hA) ? MUL_CYCLES : 1;
    endfunction

    function automatic bit op_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                          4'h8, 4'h9, 4'hA, 4'hF};
    endfunction

    function automatic bit op_writes(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                          4'h8, 4'h9, 4'hA};
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_acc = 1'b0;
        if (reset) begin
            m_act  = 1'b0;
            m_last = 16'h0000;
        end else if (!m_act) begin
            if (instr_valid) begin
                m_act  = 1'b1;
                m_acc  = 1'b1;
                m_last = instr;
                m_t    = 1;
            end
        end else if ((m_t == 1 && !op_legal(m_last[15:12])) ||
                     (m_t == exec_len(m_last[15:12]) + 2)) begin
            m_act = 1'b0;
        end else begin
            m_t++;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison of every output against the model
    // ------------------------------------------------------------------
    logic [48:0] exp_v;
    logic [48:0] act_v;

    always @(negedge clk) begin
        logic [3:0] op;
        bit         wb;
        bit         dec;
        op  = m_last[15:12];
        wb  = m_act && (m_t == exec_len(op) + 2);
        dec = m_act && (m_t == 1);
        if (reset) begin
            exp_v = '0;
        end else begin
            exp_v = {!m_act, op, m_last[11:8], m_last[3:0],
                     (op == 4'h8 || op == 4'h9),
                     {{8{m_last[7]}}, m_last[7:0]},
                     (wb && op_writes(op)) ? (16'(1) << m_last[11:8]) : 16'h0000,
                     wb && (op == 4'h6), wb, dec && !op_legal(op)};
        end
        act_v = {instr_ready, alu_op, rd_a_sel, rd_b_sel, b_sel_imm, imm_out,
                 reg_en, flag_en, done, illegal};
        compared++;
        if (act_v !== exp_v) begin
            mismatched++;
            $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act_v, exp_v);
        end
        if (done === 1'b1) done_seen++;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer a word and return one step after the accepting edge.
    task automatic send(input logic [15:0] w);
        instr       = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (m_acc) return;
        end
        compared++;
        mismatched++;
        $display("FAIL send: no handshake for %h got timeout expected accept", w);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!m_act) return;
            @(posedge clk);
            #1;
        end
        compared++;
        mismatched++;
        $display("FAIL wait_idle: got busy expected idle");
    endtask

    function automatic logic [15:0] rand_legal();
        logic [3:0] ops [11];
        logic [15:0] w;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hF};
        w = 16'($urandom);
        w[15:12] = ops[$urandom_range(0, 10)];
        return w;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int cnt;
        reset       = 1'b1;
        instr       = 16'h0000;
        instr_valid = 1'b1;   // must not handshake while reset is high
        repeat (3) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        reset       = 1'b0;

        @(negedge clk);
        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_reg_en", 32'(reg_en), 32'h0);
        chk("reset_alu_op", 32'(alu_op), 32'h0);
        chk("reset_imm", 32'(imm_out), 32'h0);

        // ADD r3,r5
        send(16'h0305);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("add_ready_low", 32'(instr_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("add_reg_en", 32'(reg_en), 32'h0008);
        chk("add_rd_a", 32'(rd_a_sel), 32'd3);
        chk("add_rd_b", 32'(rd_b_sel), 32'd5);
        chk("add_alu_op", 32'(alu_op), 32'd0);
        chk("add_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("add_ready_back", 32'(instr_ready), 32'd1);

        // ADDI r2,-1
        send(16'h82FF);
        instr_valid = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                chk("addi_imm", 32'(imm_out), 32'hFFFF);
                chk("addi_bsel", 32'(b_sel_imm), 32'd1);
            end
            if (reg_en == 16'h0004) cnt++;
        end
        chk("addi_reg_en_cycles", 32'(cnt), 32'd1);

        // MUL r1,r4
        send(16'hA104);
        instr_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("mul_ready_low", 32'(instr_ready), 32'd0);
            chk("mul_reg_en", 32'(reg_en), (k == 5) ? 32'h0002 : 32'h0);
        end
        @(negedge clk);
        chk("mul_ready_back", 32'(instr_ready), 32'd1);

        // CMP r7,r8
        send(16'h6708);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cmp_flag_en", 32'(flag_en), 32'd1);
        chk("cmp_reg_en", 32'(reg_en), 32'h0);
        chk("cmp_done", 32'(done), 32'd1);

        // Illegal 0x7000
        send(16'h7000);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_done", 32'(done), 32'd0);
        chk("ill_reg_en", 32'(reg_en), 32'h0);
        @(negedge clk);
        chk("ill_ready_back", 32'(instr_ready), 32'd1);

        // NOP
        send(16'hF000);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("nop_done", 32'(done), 32'd1);
        chk("nop_reg_en", 32'(reg_en), 32'h0);

        // MOV r9,r1 with reset during WB
        send(16'h5901);
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstwb_reg_en", 32'(reg_en), 32'h0);
        chk("rstwb_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstwb_ready", 32'(instr_ready), 32'd1);
        chk("rstwb_rd_a", 32'(rd_a_sel), 32'd0);

        // Back-to-back burst of 8 legal instructions
        done_seen = 0;
        for (int n = 0; n < 8; n++) send(rand_legal());
        instr_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("burst_done_count", 32'(done_seen), 32'd8);

        // Random traffic with gaps, illegal opcodes and occasional reset
        for (int n = 0; n < 60; n++) begin
            instr_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                instr = 16'($urandom);
                @(posedge clk); #1;
            end
            send(($urandom_range(0, 3) == 0) ? 16'($urandom) : rand_legal());
            instr       = 16'($urandom);   // ignored while busy
            instr_valid = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 5)) begin
                    @(posedge clk); #1;
                end
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
            end
            instr_valid = 1'b0;
            wait_idle();
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_regfile_seq_ctrl
`default_nettype wire
